ysyx_23060208_isram: RTL and testbench

//  Instruction SRAM read slave directly upstream of the IFU. It feeds the IFU's isram_* read channel.

---
 rtl/ysyx_23060208_isram.sv | 127 ++++++++++++
 tb/tb_ysyx_23060208_isram.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_isram.sv
// Instruction SRAM read slave (AR/R channels) with a fixed or pseudo-random response latency.
// Define ISRAM_RAND_DELAY_EN to draw each request's latency (0..3) from a 4-bit LFSR instead of FIXED_LAT.
module ysyx_23060208_isram #(
   parameter int unsigned             DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]   ADDR_BASE  = 32'h8000_0000,
   parameter int unsigned             DEPTH_LOG2 = 12,
   parameter int unsigned             FIXED_LAT  = 1,
   parameter                          INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] araddr,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic [1:0]            rresp,
   input  logic                  rready
);

   localparam logic [1:0]            RESP_OKAY   = 2'b00;
   localparam logic [1:0]            RESP_SLVERR = 2'b10;
   localparam logic [DATA_WIDTH-1:0] MEM_BYTES   = DATA_WIDTH'(4) << DEPTH_LOG2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [DATA_WIDTH-1:0] addr_q;
   logic                  arready_q;
   logic                  rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;

   logic [DATA_WIDTH-1:0] rd_off;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  rd_err;
   logic [3:0]            lat_d;

   // Backdoor patch port; shares the bus decode, so misaligned or out-of-range writes are dropped.
   task isram_write(input logic [DATA_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data);
      logic [DATA_WIDTH-1:0] off;
      off = addr - ADDR_BASE;
      if (off[1:0] == 2'b00 && off < MEM_BYTES) mem[off[DEPTH_LOG2+1:2]] = data;
   endtask

`ifdef ISRAM_RAND_DELAY_EN
   logic [3:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 4'b1001;
      else     lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
   end

   always_comb lat_d = {2'b00, lfsr_q[1:0]};
`else
   always_comb lat_d = FIXED_LAT[3:0];
`endif

   // An address below ADDR_BASE wraps to a huge offset and falls into the range error.
   always_comb begin
      rd_off = addr_q - ADDR_BASE;
      rd_idx = rd_off[DEPTH_LOG2+1:2];
      rd_err = (rd_off[1:0] != 2'b00) || (rd_off >= MEM_BYTES);
   end

   // WAIT with cnt_q==0 is the registered memory read, so a zero-latency request still
   // spends one cycle there before rvalid rises.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (state_q)
            IDLE: begin
               if (arvalid && arready_q) begin
                  addr_q    <= araddr;
                  cnt_q     <= lat_d;
                  arready_q <= 1'b0;
                  state_q   <= WAIT;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= rd_err ? '0 : mem[rd_idx];
                  rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                  state_q  <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               arready_q <= 1'b0;
               rvalid_q  <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

endmodule

// File: tb/tb_ysyx_23060208_isram.sv
// Randomized bench for ysyx_23060208_isram against a plain array model of the memory and decode rules.
module tb_ysyx_23060208_isram;
   localparam int          LAT  = 1;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic [1:0]  rresp;
   logic        rready = 1'b0;

   logic [31:0] ref_mem [0:4095];
   int n_chk  = 0;
   int n_pass = 0;

   ysyx_23060208_isram #(.DATA_WIDTH(32), .ADDR_BASE(BASE), .DEPTH_LOG2(12), .FIXED_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rresp(rresp), .rready(rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // {rresp, rdata} the slave must return for a byte address
   function automatic logic [33:0] model(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (off % 4 != 0 || off >= 32'd16384) return {2'b10, 32'h0};
      return {2'b00, ref_mem[off / 4]};
   endfunction

   // Called at a negedge. bp = cycles of rready low once rvalid is up; pend/pa re-asserts
   // arvalid during the response to check that it waits for IDLE.
   task automatic read(input logic [31:0] a, input int bp, input logic pend, input logic [31:0] pa);
      logic [33:0] exp;
      int k;
      int lat;
      exp     = model(a);
      araddr  = a;
      arvalid = 1'b1;
      rready  = (bp == 0);
      k = 0;
      while (!arready && k < 50) begin @(negedge clk); k++; end
      if (!arready) begin chk("ar_timeout", 1, 0); arvalid = 1'b0; return; end
      @(posedge clk); #1;
      arvalid = 1'b0;
      araddr  = $urandom;
      @(negedge clk);
      k = 0;
      while (!rvalid && k < 50) begin @(negedge clk); k++; end
      if (!rvalid) begin chk("r_timeout", 1, 0); return; end
      lat = k - 1;
`ifdef ISRAM_RAND_DELAY_EN
      chk("lat_range", lat >= 0 && lat <= 3, 1);
`else
      chk("lat", lat, LAT);
`endif
      chk("rdata_rresp", {rresp, rdata}, exp);
      chk("arready_busy", arready, 0);
      for (int i = 0; i < bp; i++) begin
         if (pend && i == 0) begin araddr = pa; arvalid = 1'b1; end
         @(negedge clk);
         chk("hold_rvalid", rvalid, 1);
         chk("hold_data", {rresp, rdata}, exp);
         chk("hold_arready", arready, 0);
      end
      rready = 1'b1;
      @(negedge clk);
      chk("r_done_rvalid", rvalid, 0);
      chk("r_done_arready", arready, 1);
      rready = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      for (int i = 0; i < 4096; i++) begin
         ref_mem[i] = $urandom;
         dut.isram_write(BASE + 32'(i) * 4, ref_mem[i]);
      end
      ref_mem[0] = 32'h0000_0413;
      dut.isram_write(BASE, ref_mem[0]);
      // ignored writes: below base, misaligned, past the end
      dut.isram_write(32'h7FFF_FFFC, 32'hDEAD_BEEF);
      dut.isram_write(32'h8000_0002, 32'hDEAD_BEEF);
      dut.isram_write(32'h8000_4000, 32'hDEAD_BEEF);

      // reset
      repeat (3) @(negedge clk);
      chk("rst_arready", arready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("arready_after_rst", arready, 1);

      read(32'h8000_0000, 0, 1'b0, '0);
      read(32'h8000_0004, 5, 1'b0, '0);
      read(32'h8000_0002, 0, 1'b0, '0);
      read(32'h8000_4000, 1, 1'b0, '0);
      read(32'h7FFF_FFFC, 0, 1'b0, '0);
      read(32'h8000_3FFC, 0, 1'b0, '0);

      // arvalid held through RESP is taken once, on the first IDLE cycle
      read(32'h8000_0010, 3, 1'b1, 32'h8000_0020);
      read(32'h8000_0020, 0, 1'b0, '0);
      repeat (4) begin @(negedge clk); chk("no_dup_rvalid", rvalid, 0); end

      // reset while the request is waiting on its latency
      araddr = 32'h8000_0008; arvalid = 1'b1;
      while (!arready) @(negedge clk);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_wait_rvalid", rvalid, 0);
      repeat (5) begin @(negedge clk); chk("rst_wait_quiet", rvalid, 0); end
      read(32'h8000_0008, 0, 1'b0, '0);

      for (int n = 0; n < 200; n++) begin
         case ($urandom % 8)
            0:       a = $urandom;
            1:       a = BASE + 32'($urandom % 16384) | 32'h1;
            default: a = BASE + 32'($urandom % 4096) * 4;
         endcase
         read(a, int'($urandom % 4), 1'b0, '0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
